// File: rtl/stim_expect_mem_mc_if.sv
// stim_expect_mem_mc_if: valid/ready vector stream bundle.
// The memory side drives vectors through master; the consumer uses slave.
interface stim_expect_mem_mc_if #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned IDX_W = 10
);
   logic             valid;
   logic             ready;
   logic [WIDTH-1:0] vector_out;
   logic [IDX_W-1:0] vector_idx;

   modport master (
      output valid, vector_out, vector_idx,
      input  ready
   );

   modport slave (
      input  valid, vector_out, vector_idx,
      output ready
   );
endinterface

// File: rtl/stim_expect_mem_mc.sv
// stim_expect_mem_mc: header-checked multi-channel vector streamer.
// Define STIM_EXPECT_MEM_MC_CHECKSUM_EN to check an XOR word per pass.
module stim_expect_mem_mc #(
   parameter int unsigned MEM_WIDTH      = 32,
   parameter int unsigned NUM_CH         = 2,
   parameter int unsigned ADDR_WIDTH     = 10,
   parameter int unsigned VECTOR_ID      = 0,
   parameter int unsigned VECTOR_VERSION = 0,
   parameter string       VECTOR_FILE    = "",
   parameter int unsigned VECTOR_RADIX   = 0
) (
   input  logic clock,
   input  logic reset,
   input  logic start,
   input  logic loop,
   stim_expect_mem_mc_if.master vif,
   output logic busy,
   output logic done,
   output logic wrap,
   output logic id_err,
   output logic version_err,
   output logic count_err,
   output logic checksum_err
);
   localparam int unsigned W     = NUM_CH * MEM_WIDTH;
   localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
`ifdef STIM_EXPECT_MEM_MC_CHECKSUM_EN
   localparam int unsigned NMAX  = DEPTH - 4;
`else
   localparam int unsigned NMAX  = DEPTH - 3;
`endif

   typedef enum logic [2:0] {
      S_IDLE, S_HDR, S_CHECK, S_STREAM, S_DONE, S_ERR
   } state_t;

   state_t                state;
   logic [W-1:0]          mem [DEPTH];
   logic [W-1:0]          rd_data;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic                  rd_en;
   logic [1:0]            hcnt;
   logic [MEM_WIDTH-1:0]  hdr_id;
   logic [MEM_WIDTH-1:0]  hdr_ver;
   logic [ADDR_WIDTH-1:0] n_last;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic [ADDR_WIDTH-1:0] rd_idx;
   logic                  rd_vld;
   logic [W-1:0]          b0, b1;
   logic [ADDR_WIDTH-1:0] i0, i1;
   logic [1:0]            cnt;
   logic                  pop, last_pop, issue;
   logic                  e_id, e_ver, e_cnt;
   logic [2:0]            occ;
   logic [63:0]           n64;
`ifdef STIM_EXPECT_MEM_MC_CHECKSUM_EN
   logic [W-1:0]          acc;
   logic [W-1:0]          csum;
   logic                  csum_pend;
`else
   assign checksum_err = 1'b0;
`endif

   assign vif.valid      = (cnt != 2'd0);
   assign vif.vector_out = b0;
   assign vif.vector_idx = i0;

   // single synchronous read port, one cycle latency
   always_ff @(posedge clock) begin
      if (rd_en) rd_data <= mem[rd_addr];
   end

   // header checks, read issue and flow-control accounting
   always_comb begin
      n64      = 64'(rd_data[MEM_WIDTH-1:0]);
      e_id     = hdr_id != MEM_WIDTH'(VECTOR_ID);
      e_ver    = hdr_ver != MEM_WIDTH'(VECTOR_VERSION);
      e_cnt    = n64 > 64'(NMAX);
      pop      = (cnt != 2'd0) && vif.ready;
      last_pop = pop && (i0 == n_last);
      occ      = 3'(cnt) + 3'(rd_vld) - 3'(pop);
      issue    = (state == S_STREAM) && !(last_pop && !loop)
                 && (occ < 3'd2);
      rd_en    = 1'b0;
      rd_addr  = '0;
      unique case (1'b1)
         (state == S_HDR): begin
            rd_en   = 1'b1;
            rd_addr = ADDR_WIDTH'(hcnt);
         end
`ifdef STIM_EXPECT_MEM_MC_CHECKSUM_EN
         (state == S_CHECK): begin
            rd_en   = 1'b1;
            rd_addr = rd_data[ADDR_WIDTH-1:0] + ADDR_WIDTH'(3);
         end
`endif
         issue: begin
            rd_en   = 1'b1;
            rd_addr = rd_ptr + ADDR_WIDTH'(3);
         end
         default: ;
      endcase
   end

   // control FSM, 2-entry output buffer and status flags
   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= S_IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         wrap        <= 1'b0;
         id_err      <= 1'b0;
         version_err <= 1'b0;
         count_err   <= 1'b0;
         hcnt        <= '0;
         hdr_id      <= '0;
         hdr_ver     <= '0;
         n_last      <= '0;
         rd_ptr      <= '0;
         rd_idx      <= '0;
         rd_vld      <= 1'b0;
         cnt         <= '0;
         b0          <= '0;
         b1          <= '0;
         i0          <= '0;
         i1          <= '0;
`ifdef STIM_EXPECT_MEM_MC_CHECKSUM_EN
         checksum_err <= 1'b0;
         acc          <= '0;
         csum         <= '0;
         csum_pend    <= 1'b0;
`endif
      end else begin
         wrap <= 1'b0;
         unique case (state)
            S_IDLE, S_DONE, S_ERR: begin
               if (start) begin
                  state       <= S_HDR;
                  busy        <= 1'b1;
                  done        <= 1'b0;
                  id_err      <= 1'b0;
                  version_err <= 1'b0;
                  count_err   <= 1'b0;
                  hcnt        <= '0;
`ifdef STIM_EXPECT_MEM_MC_CHECKSUM_EN
                  checksum_err <= 1'b0;
`endif
               end
            end
            S_HDR: begin
               hcnt <= hcnt + 2'd1;
               if (hcnt == 2'd1) hdr_id <= rd_data[MEM_WIDTH-1:0];
               if (hcnt == 2'd2) begin
                  hdr_ver <= rd_data[MEM_WIDTH-1:0];
                  state   <= S_CHECK;
               end
            end
            S_CHECK: begin
               id_err      <= e_id;
               version_err <= e_ver;
               count_err   <= e_cnt;
               n_last      <= rd_data[ADDR_WIDTH-1:0] - 1'b1;
               rd_ptr      <= '0;
               rd_vld      <= 1'b0;
               cnt         <= '0;
`ifdef STIM_EXPECT_MEM_MC_CHECKSUM_EN
               acc         <= '0;
               csum_pend   <= 1'b1;
`endif
               if (e_id || e_ver || e_cnt) begin
                  state <= S_ERR;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else if (n64 == 64'd0) begin
                  state <= S_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  state <= S_STREAM;
               end
            end
            S_STREAM: begin
               rd_vld <= issue;
               if (issue) begin
                  rd_idx <= rd_ptr;
                  rd_ptr <= (rd_ptr == n_last) ? '0 : rd_ptr + 1'b1;
               end
`ifdef STIM_EXPECT_MEM_MC_CHECKSUM_EN
               if (csum_pend) begin
                  csum      <= rd_data;
                  csum_pend <= 1'b0;
               end
               if (pop) begin
                  if (last_pop) begin
                     if ((acc ^ b0) != csum) checksum_err <= 1'b1;
                     acc <= '0;
                  end else begin
                     acc <= acc ^ b0;
                  end
               end
`endif
               // speculative next-pass reads are dropped when not looping
               if (last_pop && !loop) begin
                  state  <= S_DONE;
                  busy   <= 1'b0;
                  done   <= 1'b1;
                  cnt    <= '0;
                  rd_vld <= 1'b0;
               end else begin
                  if (last_pop) wrap <= 1'b1;
                  unique case ({pop, rd_vld})
                     2'b10: begin
                        b0  <= b1;
                        i0  <= i1;
                        cnt <= cnt - 2'd1;
                     end
                     2'b01: begin
                        if (cnt == 2'd0) begin
                           b0 <= rd_data;
                           i0 <= rd_idx;
                        end else begin
                           b1 <= rd_data;
                           i1 <= rd_idx;
                        end
                        cnt <= cnt + 2'd1;
                     end
                     2'b11: begin
                        if (cnt == 2'd1) begin
                           b0 <= rd_data;
                           i0 <= rd_idx;
                        end else begin
                           b0 <= b1;
                           i0 <= i1;
                           b1 <= rd_data;
                           i1 <= rd_idx;
                        end
                     end
                     default: ;
                  endcase
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_stim_expect_mem_mc.sv
// tb_stim_expect_mem_mc: directed tests plus a per-cycle stream model.
// The vector image is written into the DUT memory by hierarchy.
module tb_stim_expect_mem_mc;
   localparam int MW = 32;
   localparam int NC = 2;
   localparam int AW = 10;
   localparam int W  = MW * NC;
   localparam int DEPTH = 1 << AW;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic start = 1'b0;
   logic loop  = 1'b0;
   logic busy, done, wrap;
   logic id_err, version_err, count_err, checksum_err;

   stim_expect_mem_mc_if #(.WIDTH(W), .IDX_W(AW)) vif ();

   stim_expect_mem_mc #(
      .MEM_WIDTH(MW), .NUM_CH(NC), .ADDR_WIDTH(AW),
      .VECTOR_ID(32'h5A), .VECTOR_VERSION(3),
      .VECTOR_FILE(""), .VECTOR_RADIX(1)
   ) dut (
      .clock(clock), .reset(reset), .start(start), .loop(loop),
      .vif(vif.master),
      .busy(busy), .done(done), .wrap(wrap),
      .id_err(id_err), .version_err(version_err),
      .count_err(count_err), .checksum_err(checksum_err)
   );

   always #5 clock = ~clock;

   int n_vec = 0;
   int n_mis = 0;
   int cyc = 0;
   int rmode = 0;
   logic [W-1:0] img [DEPTH];

   // stream model state
   bit mon_on = 0;
   bit m_active = 0;
   bit m_wrap = 0;
   bit m_done = 0;
   bit m_stall = 0;
   bit m_cerr = 0;
   int m_ptr = 0;
   int m_n = 0;
   int beats = 0;
   int wraps = 0;
   int last_idx = 0;
   logic [W-1:0] m_acc = '0;
   logic [W-1:0] last_data = '0;

   function automatic void chk(input string nm, input logic [63:0] got,
                               input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endfunction

   function automatic logic [W-1:0] vec(input int k, input int seed);
      logic [MW-1:0] c0, c1;
      c0 = 32'h1000_0000 + 32'(seed) + 32'(k);
      c1 = 32'hC0DE_0000 ^ (32'(k) << 4) ^ 32'(seed);
      return {c1, c0};
   endfunction

   task automatic put(input int a, input logic [W-1:0] v);
      img[a] = v;
      dut.mem[a] = v;
   endtask

   task automatic load(input int id, input int ver, input int n,
                       input int seed);
      logic [W-1:0] cs;
      cs = '0;
      put(0, W'(id));
      put(1, W'(ver));
      put(2, W'(n));
      for (int k = 0; k < n && k < 16; k++) begin
         put(3 + k, vec(k, seed));
         cs = cs ^ vec(k, seed);
      end
      if (n < 16) put(3 + n, cs);
   endtask

   task automatic step();
      @(posedge clock);
      #1;
      cyc++;
      case (rmode)
         1: vif.ready = (cyc % 3 == 0);
         default: vif.ready = 1'b1;
      endcase
   endtask

   task automatic arm(input int n, input bit act);
      m_n = n;
      m_ptr = 0;
      m_active = act;
      m_wrap = 0;
      m_done = 0;
      m_stall = 0;
      beats = 0;
      wraps = 0;
      mon_on = 1;
   endtask

   task automatic pulse();
      start = 1'b1;
      step();
      start = 1'b0;
      m_cerr = 0;
      m_acc = '0;
   endtask

   task automatic wait_done(input int lim, output int n);
      n = 0;
      while (!done && n < lim) begin
         step();
         n++;
      end
      chk("wait_done", done, 1);
   endtask

   // compare DUT stream against the model every cycle
   always @(negedge clock) begin
      if (mon_on) begin
         chk("wrap", wrap, m_wrap);
         m_wrap = 0;
         if (m_done) begin
            chk("done_after_last", done, 1);
            chk("busy_after_last", busy, 0);
            m_done = 0;
         end
         chk("checksum_err", checksum_err, m_cerr);
         if (m_stall) chk("stall_hold", vif.valid, 1);
         if (!m_active) chk("valid_idle", vif.valid, 0);
         if (vif.valid && m_active) begin
            chk("idx", 64'(vif.vector_idx), 64'(m_ptr));
            chk("data", vif.vector_out, img[3 + m_ptr]);
            if (vif.ready) begin
               beats++;
               last_idx = int'(vif.vector_idx);
               last_data = vif.vector_out;
               m_acc = m_acc ^ vif.vector_out;
               if (m_ptr == m_n - 1) begin
`ifdef STIM_EXPECT_MEM_MC_CHECKSUM_EN
                  if (m_acc != img[3 + m_n]) m_cerr = 1;
`endif
                  m_acc = '0;
                  if (loop) begin
                     m_ptr = 0;
                     m_wrap = 1;
                     wraps++;
                  end else begin
                     m_active = 0;
                     m_done = 1;
                  end
               end else begin
                  m_ptr++;
               end
            end
         end
         m_stall = vif.valid && !vif.ready;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n;
      bit cs_exp;
      vif.ready = 1'b1;
      step();
      step();
      chk("rst_valid", vif.valid, 0);
      chk("rst_vector_out", vif.vector_out, 0);
      chk("rst_idx", 64'(vif.vector_idx), 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_wrap", wrap, 0);
      chk("rst_errs", {id_err, version_err, count_err, checksum_err}, 0);
      reset = 1'b0;
      step();

      // basic run, N=4, ready high
      load(32'h5A, 3, 4, 0);
      arm(4, 1);
      pulse();
      chk("t1_busy_E0", busy, 1);
      repeat (5) step();
      chk("t1_valid_E5", vif.valid, 0);
      step();
      chk("t1_valid_E6", vif.valid, 1);
      chk("t1_vec0", vif.vector_out, 64'hC0DE0000_10000000);
      chk("t1_idx0", 64'(vif.vector_idx), 0);
      wait_done(50, n);
      chk("t1_done_latency", 64'(n), 4);
      chk("t1_beats", 64'(beats), 4);
      chk("t1_last", last_data, 64'hC0DE0030_10000003);
      chk("t1_errs", {id_err, version_err, count_err}, 0);
      repeat (3) step();

      // bad ID, twice
      load(32'h5B, 3, 4, 0);
      arm(4, 0);
      for (int r = 0; r < 2; r++) begin
         pulse();
         chk("t2_busy_E0", busy, 1);
         chk("t2_idcleared_E0", id_err, 0);
         repeat (3) step();
         chk("t2_done_E3", done, 0);
         step();
         chk("t2_id_err_E4", id_err, 1);
         chk("t2_done_E4", done, 1);
         chk("t2_busy_E4", busy, 0);
         chk("t2_other_errs", {version_err, count_err}, 0);
         repeat (3) step();
      end

      // stalls with ready pattern 1,0,0
      load(32'h5A, 3, 3, 7);
      arm(3, 1);
      rmode = 1;
      pulse();
      wait_done(100, n);
      chk("t3_beats", 64'(beats), 3);
      chk("t3_last_idx", 64'(last_idx), 2);
      rmode = 0;
      step();

      // looping N=2, then stop
      load(32'h5A, 3, 2, 32'h20);
      arm(2, 1);
      loop = 1'b1;
      pulse();
      repeat (14) step();
      chk("t4_wraps", 64'(wraps), 4);
      chk("t4_beats", 64'(beats), 8);
      loop = 1'b0;
      wait_done(20, n);
      chk("t4_last_idx", 64'(last_idx), 1);
      step();

      // count too large, then N=0
      load(32'h5A, 3, DEPTH - 2, 0);
      arm(0, 0);
      pulse();
      repeat (4) step();
      chk("t5_count_err", count_err, 1);
      chk("t5_done", done, 1);
      chk("t5_id_err", id_err, 0);
      load(32'h5A, 3, 0, 0);
      pulse();
      repeat (3) step();
      chk("t5_n0_done_E3", done, 0);
      step();
      chk("t5_n0_done_E4", done, 1);
      chk("t5_n0_busy", busy, 0);
      chk("t5_n0_errs", {id_err, version_err, count_err}, 0);
      repeat (6) step();

      // corrupted checksum word
      load(32'h5A, 3, 4, 32'h33);
      put(7, img[7] ^ 64'h1);
`ifdef STIM_EXPECT_MEM_MC_CHECKSUM_EN
      cs_exp = 1;
`else
      cs_exp = 0;
`endif
      arm(4, 1);
      pulse();
      wait_done(50, n);
      chk("t6_checksum_err", checksum_err, 64'(cs_exp));
      step();

      // reset mid-stream, then reset over start
      load(32'h5A, 3, 4, 0);
      arm(4, 1);
      loop = 1'b1;
      pulse();
      repeat (9) step();
      chk("t7_streaming", vif.valid, 1);
      mon_on = 0;
      reset = 1'b1;
      start = 1'b1;
      step();
      chk("t7_valid", vif.valid, 0);
      chk("t7_vector_out", vif.vector_out, 0);
      chk("t7_idx", 64'(vif.vector_idx), 0);
      chk("t7_busy", busy, 0);
      chk("t7_done", done, 0);
      chk("t7_wrap", wrap, 0);
      chk("t7_errs", {id_err, version_err, count_err, checksum_err}, 0);
      start = 1'b0;
      reset = 1'b0;
      loop = 1'b0;
      step();
      chk("t7_idle_busy", busy, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end
endmodule
